// File: rtl/alu_pwr_pkg.sv
// Shared types and defaults for the ALU power-domain sequencer.
// Retention (SAVE/RESTORE) is built in when ALU_PWR_RETENTION_EN is defined.
package alu_pwr_pkg;

    localparam int TMR_W             = 8;
    localparam int ISO_CYC_DEF       = 2;
    localparam int PWRUP_CYC_DEF     = 4;
    localparam int DRAIN_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISO     = 3'd2,
        ST_SAVE    = 3'd3,
        ST_OFF     = 3'd4,
        ST_RAMP    = 3'd5,
        ST_RESTORE = 3'd6
    } pwr_state_e;

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable 8-bit down-counter with zero flag; holds at zero instead of wrapping.
// Shared by the DRAIN, ISO and RAMP phases of alu_pwr_seq.
module alu_pwr_timer
    import alu_pwr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// ALU power-domain sequencer: drain, isolate, (save), power off, ramp, (restore).
// Define ALU_PWR_RETENTION_EN to include the SAVE/RESTORE retention states.
//
// state   | meaning
// ON      | domain powered, ALU usable
// DRAIN   | waiting for in-flight op to finish (bounded by DRAIN_TIMEOUT)
// ISO     | outputs clamped for ISO_CYC cycles before save/off
// SAVE    | one-cycle retention save pulse
// OFF     | domain unpowered, isolated
// RAMP    | power enabled, waiting PWRUP_CYC cycles for rail to settle
// RESTORE | one-cycle retention restore pulse
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int ISO_CYC       = ISO_CYC_DEF,
    parameter int PWRUP_CYC     = PWRUP_CYC_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_down_req,
    input  logic pwr_up_req,
    input  logic alu_busy,
    output logic alu_pwr_en,
    output logic iso_en,
    output logic save,
    output logic restore,
    output logic alu_ready,
    output logic pwr_off,
    output logic down_ack,
    output logic up_ack,
    output logic drain_tmo
);

    // Timer is loaded with N-1 so the phase exits on the Nth edge it is seen at zero.
    localparam logic [TMR_W-1:0] ISO_LD   = TMR_W'(ISO_CYC - 1);
    localparam logic [TMR_W-1:0] PWRUP_LD = TMR_W'(PWRUP_CYC - 1);
    localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(DRAIN_TIMEOUT - 1);

    pwr_state_e       state, state_nxt;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             down_ack_nxt, up_ack_nxt, drain_tmo_nxt;

    alu_pwr_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt     = state;
        down_ack_nxt  = 1'b0;
        up_ack_nxt    = 1'b0;
        drain_tmo_nxt = 1'b0;
        case (state)
            ST_ON: begin
                if (pwr_down_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pwr_up_req) begin
                    state_nxt = ST_ON;
                end else if (!alu_busy) begin
                    state_nxt = ST_ISO;
                end else if (tmr_zero) begin
                    state_nxt     = ST_ON;
                    drain_tmo_nxt = 1'b1;
                end
            end
            ST_ISO: begin
                if (tmr_zero) begin
`ifdef ALU_PWR_RETENTION_EN
                    state_nxt = ST_SAVE;
`else
                    state_nxt    = ST_OFF;
                    down_ack_nxt = 1'b1;
`endif
                end
            end
            ST_SAVE: begin
                state_nxt    = ST_OFF;
                down_ack_nxt = 1'b1;
            end
            ST_OFF: begin
                if (pwr_up_req) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (tmr_zero) begin
`ifdef ALU_PWR_RETENTION_EN
                    state_nxt = ST_RESTORE;
`else
                    state_nxt  = ST_ON;
                    up_ack_nxt = 1'b1;
`endif
                end
            end
            ST_RESTORE: begin
                state_nxt  = ST_ON;
                up_ack_nxt = 1'b1;
            end
            default: state_nxt = ST_ON;
        endcase
    end

    always_comb begin
        tmr_load = (state_nxt != state);
        case (state_nxt)
            ST_DRAIN: tmr_val = DRAIN_LD;
            ST_ISO:   tmr_val = ISO_LD;
            ST_RAMP:  tmr_val = PWRUP_LD;
            default:  tmr_val = '0;
        endcase
    end

    // Outputs decode the next state so they are valid in the cycle the state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ON;
            alu_pwr_en <= 1'b1;
            iso_en     <= 1'b0;
            alu_ready  <= 1'b1;
            pwr_off    <= 1'b0;
            down_ack   <= 1'b0;
            up_ack     <= 1'b0;
            drain_tmo  <= 1'b0;
        end else begin
            state      <= state_nxt;
            alu_pwr_en <= (state_nxt != ST_OFF);
            iso_en     <= (state_nxt != ST_ON) && (state_nxt != ST_DRAIN);
            alu_ready  <= (state_nxt == ST_ON);
            pwr_off    <= (state_nxt == ST_OFF);
            down_ack   <= down_ack_nxt;
            up_ack     <= up_ack_nxt;
            drain_tmo  <= drain_tmo_nxt;
        end
    end

`ifdef ALU_PWR_RETENTION_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            save    <= 1'b0;
            restore <= 1'b0;
        end else begin
            save    <= (state_nxt == ST_SAVE);
            restore <= (state_nxt == ST_RESTORE);
        end
    end
`else
    assign save    = 1'b0;
    assign restore = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Self-checking bench for alu_pwr_seq: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a phase/age reference model.
module tb_alu_pwr_seq;

    localparam int ISO_C   = 2;
    localparam int PWRUP_C = 3;
    localparam int DRAIN_T = 16;
`ifdef ALU_PWR_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif
    localparam int DN_E = RET ? 5 : 4;
    localparam int UP_E = RET ? 5 : 4;

    localparam int P_ON = 0, P_DRAIN = 1, P_ISO = 2, P_SAVE = 3,
                   P_OFF = 4, P_RAMP = 5, P_RESTORE = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwr_down_req = 1'b0;
    logic pwr_up_req = 1'b0;
    logic alu_busy = 1'b0;
    logic alu_pwr_en, iso_en, save, restore, alu_ready, pwr_off;
    logic down_ack, up_ack, drain_tmo;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase = P_ON;
    int m_age   = 0;
    bit m_valid = 1'b0;
    bit m_dack, m_uack, m_tmo;

    alu_pwr_seq #(
        .ISO_CYC       (ISO_C),
        .PWRUP_CYC     (PWRUP_C),
        .DRAIN_TIMEOUT (DRAIN_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwr_down_req (pwr_down_req),
        .pwr_up_req   (pwr_up_req),
        .alu_busy     (alu_busy),
        .alu_pwr_en   (alu_pwr_en),
        .iso_en       (iso_en),
        .save         (save),
        .restore      (restore),
        .alu_ready    (alu_ready),
        .pwr_off      (pwr_off),
        .down_ack     (down_ack),
        .up_ack       (up_ack),
        .drain_tmo    (drain_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a phase plus the number of edges spent in it; durations compared directly.
    task automatic model_step();
        int nxt;
        m_dack = 1'b0;
        m_uack = 1'b0;
        m_tmo  = 1'b0;
        if (rst) begin
            m_phase = P_ON;
            m_age   = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        nxt = m_phase;
        case (m_phase)
            P_ON:      if (pwr_down_req) nxt = P_DRAIN;
            P_DRAIN: begin
                if (pwr_up_req) nxt = P_ON;
                else if (!alu_busy) nxt = P_ISO;
                else if (m_age + 1 >= DRAIN_T) begin
                    nxt   = P_ON;
                    m_tmo = 1'b1;
                end
            end
            P_ISO:     if (m_age + 1 >= ISO_C) nxt = RET ? P_SAVE : P_OFF;
            P_SAVE:    nxt = P_OFF;
            P_OFF:     if (pwr_up_req) nxt = P_RAMP;
            P_RAMP:    if (m_age + 1 >= PWRUP_C) nxt = RET ? P_RESTORE : P_ON;
            P_RESTORE: nxt = P_ON;
            default:   nxt = P_ON;
        endcase
        if (nxt == P_OFF && m_phase != P_OFF) m_dack = 1'b1;
        if (nxt == P_ON && (m_phase == P_RAMP || m_phase == P_RESTORE)) m_uack = 1'b1;
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check("m_pwr_en",  alu_pwr_en, m_phase != P_OFF);
            check("m_iso",     iso_en,     m_phase != P_ON && m_phase != P_DRAIN);
            check("m_save",    save,       m_phase == P_SAVE);
            check("m_restore", restore,    m_phase == P_RESTORE);
            check("m_ready",   alu_ready,  m_phase == P_ON);
            check("m_off",     pwr_off,    m_phase == P_OFF);
            check("m_dack",    down_ack,   m_dack);
            check("m_uack",    up_ack,     m_uack);
            check("m_tmo",     drain_tmo,  m_tmo);
        end
    end

    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit reached;

        repeat (2) @(posedge clk);
        #2;
        check("rst_pwr_en",  alu_pwr_en, 1'b1);
        check("rst_iso",     iso_en,     1'b0);
        check("rst_save",    save,       1'b0);
        check("rst_restore", restore,    1'b0);
        check("rst_ready",   alu_ready,  1'b1);
        check("rst_off",     pwr_off,    1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Power-down with idle ALU.
        @(negedge clk);
        pwr_down_req = 1'b1;
        alu_busy = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            edge_wait();
            check("dn_iso",    iso_en,     e >= 2);
            check("dn_pwr_en", alu_pwr_en, e < DN_E);
            check("dn_save",   save,       RET && e == 4);
            check("dn_ack",    down_ack,   e == DN_E);
            check("dn_ready",  alu_ready,  1'b0);
        end

        // Power-up from OFF.
        @(negedge clk);
        pwr_down_req = 1'b0;
        pwr_up_req = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            edge_wait();
            check("up_pwr_en",  alu_pwr_en, 1'b1);
            check("up_restore", restore,    RET && e == 4);
            check("up_ack",     up_ack,     e == UP_E);
            check("up_ready",   alu_ready,  e >= UP_E);
            check("up_iso",     iso_en,     e < UP_E);
        end
        @(negedge clk) pwr_up_req = 1'b0;

        // Drain timeout with ALU held busy.
        @(negedge clk);
        pwr_down_req = 1'b1;
        alu_busy = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            edge_wait();
            check("tmo_pulse", drain_tmo, e == 17);
            check("tmo_iso",   iso_en,    1'b0);
            check("tmo_ready", alu_ready, e >= 17);
            if (e == 16) begin
                @(negedge clk) pwr_down_req = 1'b0;
            end
        end
        @(negedge clk) alu_busy = 1'b0;

        // Reset in the middle of the ramp.
        @(negedge clk) pwr_down_req = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            edge_wait();
            if (pwr_off) reached = 1'b1;
        end
        check("reach_off", reached, 1'b1);
        @(negedge clk);
        pwr_down_req = 1'b0;
        pwr_up_req = 1'b1;
        edge_wait();
        edge_wait();
        @(negedge clk) rst = 1'b1;
        edge_wait();
        check("rr_iso",    iso_en,     1'b0);
        check("rr_up_ack", up_ack,     1'b0);
        check("rr_ready",  alu_ready,  1'b1);
        check("rr_pwr_en", alu_pwr_en, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        pwr_up_req = 1'b0;

        // Random traffic; the per-cycle model compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom % 97) == 0;
            if (((c / 128) % 2) == 0) begin
                alu_busy     = ($urandom % 20) != 0;
                pwr_up_req   = ($urandom % 40) == 0;
                pwr_down_req = ($urandom % 4) == 0;
            end else begin
                alu_busy     = ($urandom % 10) < 3;
                pwr_up_req   = ($urandom % 7) == 0;
                pwr_down_req = ($urandom % 3) == 0;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pwr_seq.md
ALU_PWR_SEQ -- requirements
Module: alu_pwr_seq

Interface
REQ-001 The block SHALL take parameter ISO_CYC, default 2, meaning cycles isolation is held before save/power-off (legal 1..255).
REQ-002 The block SHALL take parameter PWRUP_CYC, default 4, meaning power-ramp cycles after alu_pwr_en rises before restore (legal 1..255).
REQ-003 The block SHALL take parameter DRAIN_TIMEOUT, default 16, meaning maximum cycles waiting for the ALU to go idle (legal 1..255).
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pwr_down_req  in  1  level request to power the ALU domain down.
- pwr_up_req  in  1  level request to power the ALU domain up.
- alu_busy  in  1  ALU multi-cycle op in flight.
- alu_pwr_en  out  1  ALU domain power enable.
- iso_en  out  1  clamp ALU outputs to zero.
- save  out  1  one-cycle retention save pulse.
- restore  out  1  one-cycle retention restore pulse.
- alu_ready  out  1  high only in ON; requesters may assert ALU start.
- pwr_off  out  1  high only in OFF.
- down_ack  out  1  one-cycle pulse on entering OFF.
- up_ack  out  1  one-cycle pulse on re-entering ON from RESTORE.
- drain_tmo  out  1  one-cycle pulse on drain timeout abort.

Function
REQ-005 The FSM SHALL have states ON, DRAIN, ISO, SAVE, OFF, RAMP, RESTORE; all outputs registered, decoded from the next state so they are valid in the cycle the state is entered.
REQ-006 Output map SHALL be: ON pwr_en=1 iso=0; DRAIN pwr_en=1 iso=0 alu_ready=0; ISO/SAVE pwr_en=1 iso=1; OFF pwr_en=0 iso=1; RAMP/RESTORE pwr_en=1 iso=1; save=1 only in SAVE; restore=1 only in RESTORE.
REQ-007 ON -> DRAIN when pwr_down_req=1; pwr_up_req is ignored in ON.
REQ-008 DRAIN -> ISO when alu_busy=0; DRAIN -> ON with drain_tmo pulse after DRAIN_TIMEOUT consecutive DRAIN cycles with alu_busy=1; DRAIN -> ON without pulse if pwr_up_req=1 (cancel; cancel wins over alu_busy=0 in the same cycle).
REQ-009 ISO SHALL last exactly ISO_CYC cycles, then -> SAVE; once ISO is entered the down sequence SHALL complete regardless of requests.
REQ-010 SAVE SHALL last one cycle, then -> OFF with down_ack pulse.
REQ-011 OFF -> RAMP when pwr_up_req=1; pwr_down_req ignored in OFF; if both high, up wins.
REQ-012 RAMP SHALL last exactly PWRUP_CYC cycles, then -> RESTORE (one cycle), then -> ON with up_ack pulse.
REQ-013 The shared timer SHALL be 8-bit, load at state entry, and never wrap; out-of-range parameters are illegal and need not be checked.

Reset
REQ-014 rst=1 SHALL force state ON at the next edge from any state, including mid-sequence: alu_pwr_en=1, iso_en=0, alu_ready=1, all other outputs 0, timer 0.

Configuration
REQ-015 With ALU_PWR_RETENTION_EN defined, SAVE and RESTORE states SHALL exist as above.
REQ-016 Without ALU_PWR_RETENTION_EN, SAVE and RESTORE SHALL be removed: ISO -> OFF directly (down_ack there), RAMP -> ON directly (up_ack there); save and restore tied 0.

Structure
REQ-017 Package alu_pwr_pkg SHALL hold the state enum, timer width constant (8) and default parameter values.
REQ-018 One sub-module alu_pwr_timer (loadable 8-bit down-counter with zero flag) SHALL serve ISO, RAMP and DRAIN timing.

Verification (ISO_CYC=2, PWRUP_CYC=3, DRAIN_TIMEOUT=16, macro defined unless stated)
REQ-019 rst=1 two cycles -> alu_pwr_en=1, iso_en=0, save=restore=0, alu_ready=1, pwr_off=0.
REQ-020 pwr_down_req sampled at edge 0, alu_busy=0 -> DRAIN edge 1, iso_en=1 edges 2-3, save=1 edge 4 only, alu_pwr_en=0 and down_ack edge 5.
REQ-021 In OFF, pwr_up_req at edge 0 -> alu_pwr_en=1 edge 1, restore=1 edge 4 only, iso_en=0, alu_ready=1 and up_ack edge 5.
REQ-022 pwr_down_req with alu_busy held 20 cycles -> drain_tmo pulse after 16 DRAIN cycles, back in ON, iso_en never asserted.
REQ-023 Macro undefined, scenario REQ-020 -> alu_pwr_en=0 and down_ack at edge 4; save/restore never assert.
REQ-024 rst=1 during RAMP cycle 2 -> ON next edge, iso_en=0, no up_ack.
